// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares the single buart TX path between a FIFO-buffered CPU
// requester (A) and an unbuffered handshake requester (B). One byte in flight
// at a time, round-robin when both are pending, and a bounded wait for the
// UART busy edge so a missed busy never stalls the scheduler.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   S_IDLE      | waiting for UART idle and a pending requester; grants
//   S_ISSUE     | one-cycle write strobe; pops FIFO (A) or acks B
//   S_WAIT_BUSY | waiting for tx_busy to rise, bounded by BUSY_TO cycles
//   S_WAIT_DONE | UART transmitting; wait for tx_busy to fall
module uart_tx_sched #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int BUSY_TO = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [7:0]    a_data,
  output logic          a_ready,
  input  logic          b_req,
  input  logic [7:0]    b_data,
  output logic          b_ack,
  output logic [AW:0]   fifo_count,
  output logic          ovf,
  output logic          tx_wr,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
);

  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [TW-1:0] TO_ONE   = 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  typedef enum logic {
    GR_A = 1'b0,
    GR_B = 1'b1
  } grant_t;

  state_t        r_state;
  state_t        w_state_nxt;
  grant_t        r_grant;
  grant_t        r_last_grant;
  grant_t        w_grant;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [7:0]    r_tx_data;
  logic [TW-1:0] r_to;

  logic w_push;
  logic w_pop;
  logic w_a_pend;
  logic w_b_pend;
  logic w_grant_en;
  logic w_to_done;

  assign a_ready    = (r_count < FULL_CNT);
  assign w_push     = a_valid && a_ready;
  assign w_a_pend   = (r_count != '0);
  assign w_b_pend   = b_req;
  assign w_to_done  = (r_to == TO_LAST);
  assign fifo_count = r_count;
  assign ovf        = r_ovf;
  assign tx_data    = r_tx_data;

  // FIFO storage; contents are not reset, the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= a_data;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop nets to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a CPU byte offered while the FIFO is full is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (a_valid && !a_ready) begin
      r_ovf <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, arbitration and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = GR_A;
    w_grant_en  = 1'b0;
    w_pop       = 1'b0;
    tx_wr       = 1'b0;
    b_ack       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!tx_busy && (w_a_pend || w_b_pend)) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_ISSUE;
          if (w_a_pend && w_b_pend) begin
            if (r_last_grant == GR_A) w_grant = GR_B;
            else                      w_grant = GR_A;
          end else if (w_b_pend) begin
            w_grant = GR_B;
          end else begin
            w_grant = GR_A;
          end
        end
      end
      S_ISSUE: begin
        tx_wr       = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
        if (r_grant == GR_A) w_pop = 1'b1;
        else                 b_ack = 1'b1;
      end
      S_WAIT_BUSY: begin
        if (tx_busy)        w_state_nxt = S_WAIT_DONE;
        else if (w_to_done) w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch grant and outgoing byte at grant time; tx_data holds until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= GR_A;
      r_last_grant <= GR_B;
      r_tx_data    <= 8'h00;
    end else if (w_grant_en) begin
      r_grant      <= w_grant;
      r_last_grant <= w_grant;
      if (w_grant == GR_A) r_tx_data <= r_mem[r_rptr];
      else                 r_tx_data <= b_data;
    end
  end

  // Busy-edge timeout: cleared in ISSUE, counts idle cycles in WAIT_BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to <= '0;
    end else if (r_state == S_ISSUE) begin
      r_to <= '0;
    end else if ((r_state == S_WAIT_BUSY) && !tx_busy) begin
      r_to <= r_to + TO_ONE;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched with a simple buart busy model and a
// log of every write strobe (byte, ack flag, cycle).
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_ready;
  logic       b_req = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_ack;
  logic [4:0] fifo_count;
  logic       ovf;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy_man = 1'b0;
  logic       busy_auto = 1'b0;
  logic       auto_en = 1'b0;
  int         auto_cnt = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int b_ack_n = 0;
  logic [7:0] txq[$];
  logic       ackq[$];
  int         cycq[$];

  assign tx_busy = busy_man | busy_auto;

  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH(16), .AW(4), .BUSY_TO(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
    .fifo_count(fifo_count), .ovf(ovf),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  // Strobe log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_wr) begin
      txq.push_back(tx_data);
      ackq.push_back(b_ack);
      cycq.push_back(cyc);
    end
    if (b_ack) b_ack_n <= b_ack_n + 1;
  end

  // buart model: busy rises the cycle after a strobe and stays high 10 cycles.
  always @(posedge clk) begin
    if (!auto_en) begin
      busy_auto <= 1'b0;
      auto_cnt  <= 0;
    end else if (tx_wr) begin
      busy_auto <= 1'b1;
      auto_cnt  <= 10;
    end else if (auto_cnt > 1) begin
      auto_cnt  <= auto_cnt - 1;
    end else begin
      busy_auto <= 1'b0;
      auto_cnt  <= 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; a_valid = 1'b0; b_req = 1'b0; busy_man = 1'b0; auto_en = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_valid = 1'b0; b_req = 1'b0;
    repeat (2) tick();
    checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL rst_tx_wr: got %b expected 0", tx_wr); end
    checks++; if (b_ack !== 1'b0) begin errors++; $display("FAIL rst_b_ack: got %b expected 0", b_ack); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %b expected 1", a_ready); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_cpu();
    int s;
    s = txq.size();
    auto_en = 1'b1;
    a_valid = 1'b1; a_data = 8'h41;
    tick();
    a_valid = 1'b0;
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL single_cnt_n1: got %0d expected 1", fifo_count); end
    checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL single_wr_n1: got %b expected 0", tx_wr); end
    tick();
    checks++; if (tx_wr !== 1'b1) begin errors++; $display("FAIL single_wr_n2: got %b expected 1", tx_wr); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", tx_data); end
    tick();
    checks++; if (tx_wr !== 1'b0) begin errors++; $display("FAIL single_wr_n3: got %b expected 0", tx_wr); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL single_cnt_n3: got %0d expected 0", fifo_count); end
    repeat (20) tick();
    checks++; if (txq.size() - s !== 1) begin errors++; $display("FAIL single_nstrobe: got %0d expected 1", txq.size() - s); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL single_hold: got %h expected 41", tx_data); end
    // a second byte shows the FSM is back in IDLE with the same latency
    a_valid = 1'b1; a_data = 8'h42;
    tick();
    a_valid = 1'b0;
    tick();
    checks++; if (tx_wr !== 1'b1 || tx_data !== 8'h42) begin errors++; $display("FAIL single_second: got wr=%b data=%h expected wr=1 data=42", tx_wr, tx_data); end
    repeat (20) tick();
    auto_en = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int s;
    int n;
    do_reset();
    busy_man = 1'b1;
    s = txq.size();
    for (int i = 0; i < 17; i++) begin
      if (i == 15) begin
        checks++; if (a_ready !== 1'b1 || fifo_count !== 5'd15) begin errors++; $display("FAIL ovf_pre15: got ready=%b cnt=%0d expected ready=1 cnt=15", a_ready, fifo_count); end
      end
      if (i == 16) begin
        checks++; if (a_ready !== 1'b0 || fifo_count !== 5'd16 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_full: got ready=%b cnt=%0d ovf=%b expected ready=0 cnt=16 ovf=0", a_ready, fifo_count, ovf); end
      end
      a_valid = 1'b1; a_data = 8'(i);
      tick();
    end
    a_valid = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", fifo_count); end
    busy_man = 1'b0; auto_en = 1'b1;
    n = 0;
    while (txq.size() - s < 16 && n < 2000) begin tick(); n++; end
    checks++; if (txq.size() - s < 16) begin errors++; $display("FAIL ovf_drain_timeout: got %0d bytes expected 16", txq.size() - s); end
    repeat (20) tick();
    checks++; if (txq.size() - s !== 16) begin errors++; $display("FAIL ovf_nbytes: got %0d expected 16", txq.size() - s); end
    for (int i = 0; i < 16; i++) begin
      if (s + i < txq.size()) begin
        checks++; if (txq[s + i] !== 8'(i)) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, txq[s + i], 8'(i)); end
      end
    end
    checks++; if (fifo_count !== 5'd0 || a_ready !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_after: got cnt=%0d ready=%b ovf=%b expected cnt=0 ready=1 ovf=1", fifo_count, a_ready, ovf); end
    auto_en = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int s;
    int k;
    int n;
    logic [7:0] exp_d [3];
    logic       exp_a [3];
    exp_d[0] = 8'h10; exp_d[1] = 8'hB0; exp_d[2] = 8'h11;
    exp_a[0] = 1'b0;  exp_a[1] = 1'b1;  exp_a[2] = 1'b0;
    do_reset();
    busy_man = 1'b1;
    s = txq.size();
    k = b_ack_n;
    a_valid = 1'b1; a_data = 8'h10;
    tick();
    a_data = 8'h11; b_req = 1'b1; b_data = 8'hB0;
    tick();
    a_valid = 1'b0;
    busy_man = 1'b0; auto_en = 1'b1;
    n = 0;
    while (txq.size() - s < 3 && n < 500) begin
      tick(); n++;
      if (b_ack) b_req = 1'b0;
    end
    checks++; if (txq.size() - s < 3) begin errors++; $display("FAIL rr_timeout: got %0d bytes expected 3", txq.size() - s); end
    repeat (15) tick();
    for (int i = 0; i < 3; i++) begin
      if (s + i < txq.size()) begin
        checks++; if (txq[s + i] !== exp_d[i]) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, txq[s + i], exp_d[i]); end
        checks++; if (ackq[s + i] !== exp_a[i]) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, ackq[s + i], exp_a[i]); end
      end
    end
    checks++; if (b_ack_n - k !== 1) begin errors++; $display("FAIL rr_nack: got %0d expected 1", b_ack_n - k); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rr_count: got %0d expected 0", fifo_count); end
    auto_en = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int s;
    int n;
    do_reset();
    s = txq.size();
    a_valid = 1'b1; a_data = 8'h55;
    tick();
    a_data = 8'h66;
    tick();
    a_valid = 1'b0;
    n = 0;
    while (txq.size() - s < 2 && n < 100) begin tick(); n++; end
    checks++; if (txq.size() - s < 2) begin errors++; $display("FAIL to_stall: got %0d bytes expected 2", txq.size() - s); end
    else begin
      checks++; if (cycq[s + 1] - cycq[s] !== 6) begin errors++; $display("FAIL to_spacing: got %0d cycles expected 6", cycq[s + 1] - cycq[s]); end
      checks++; if (txq[s] !== 8'h55 || txq[s + 1] !== 8'h66) begin errors++; $display("FAIL to_data: got %h %h expected 55 66", txq[s], txq[s + 1]); end
    end
    repeat (20) tick();
    checks++; if (txq.size() - s !== 2 || fifo_count !== 5'd0) begin errors++; $display("FAIL to_after: got n=%0d cnt=%0d expected n=2 cnt=0", txq.size() - s, fifo_count); end
  endtask

  task automatic test_reset_wait_done();
    int s;
    do_reset();
    busy_man = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_data = 8'hA0 + 8'(i);
      tick();
    end
    a_valid = 1'b0;
    checks++; if (fifo_count !== 5'd4) begin errors++; $display("FAIL rwd_fill: got %0d expected 4", fifo_count); end
    busy_man = 1'b0;
    tick();
    checks++; if (tx_wr !== 1'b1 || tx_data !== 8'hA0) begin errors++; $display("FAIL rwd_issue: got wr=%b data=%h expected wr=1 data=a0", tx_wr, tx_data); end
    busy_man = 1'b1;
    repeat (3) tick();
    checks++; if (fifo_count !== 5'd3 || tx_wr !== 1'b0) begin errors++; $display("FAIL rwd_queued: got cnt=%0d wr=%b expected cnt=3 wr=0", fifo_count, tx_wr); end
    s = txq.size();
    reset = 1'b1;
    tick();
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rwd_count: got %0d expected 0", fifo_count); end
    checks++; if (tx_wr !== 1'b0 || b_ack !== 1'b0) begin errors++; $display("FAIL rwd_strobes: got wr=%b ack=%b expected 0 0", tx_wr, b_ack); end
    checks++; if (a_ready !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL rwd_flags: got ready=%b ovf=%b expected 1 0", a_ready, ovf); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rwd_data: got %h expected 00", tx_data); end
    reset = 1'b0;
    repeat (2) tick();
    busy_man = 1'b0;
    repeat (20) tick();
    checks++; if (txq.size() !== s) begin errors++; $display("FAIL rwd_no_tx: got %0d strobes expected 0", txq.size() - s); end
  endtask

  task automatic test_b_latency();
    do_reset();
    b_req = 1'b1; b_data = 8'h3C;
    tick();
    checks++; if (tx_wr !== 1'b1 || b_ack !== 1'b1) begin errors++; $display("FAIL blat_strobe: got wr=%b ack=%b expected 1 1", tx_wr, b_ack); end
    checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL blat_data: got %h expected 3c", tx_data); end
    b_data = 8'hFF;
    tick();
    b_req = 1'b0;
    checks++; if (tx_wr !== 1'b0 || b_ack !== 1'b0 || tx_data !== 8'h3C) begin errors++; $display("FAIL blat_after: got wr=%b ack=%b data=%h expected 0 0 3c", tx_wr, b_ack, tx_data); end
    repeat (10) tick();
  endtask

  task automatic test_b_withdraw();
    int s;
    int k;
    do_reset();
    s = txq.size();
    k = b_ack_n;
    busy_man = 1'b1;
    b_req = 1'b1; b_data = 8'hC5;
    repeat (5) tick();
    b_req = 1'b0;
    tick();
    busy_man = 1'b0;
    repeat (15) tick();
    checks++; if (b_ack_n !== k) begin errors++; $display("FAIL bwd_ack: got %0d acks expected 0", b_ack_n - k); end
    checks++; if (txq.size() !== s) begin errors++; $display("FAIL bwd_tx: got %0d strobes expected 0", txq.size() - s); end
  endtask

  initial begin
    test_reset();
    test_single_cpu();
    test_overflow();
    test_round_robin();
    test_timeout();
    test_reset_wait_done();
    test_b_latency();
    test_b_withdraw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Transmit-side scheduler for the board's single buart instance.
- Shares the UART TX path between two requesters:
  - A: the CPU I/O write path (io_wr to 0x1000), buffered through an internal FIFO.
  - B: an unbuffered hardware requester (boot/trace monitor), single-byte handshake.
- Owns the buart `wr`/`tx_data` pins, sequences each byte against `busy`, and arbitrates round-robin.

Parameters:
- DEPTH, 16, CPU FIFO entries; must be a power of 2, minimum 2.
- AW, 4, log2(DEPTH).
- BUSY_TO, 4, maximum cycles to wait for tx_busy to rise after a write strobe.

Ports:
- clk  in  1  system clock (fclk).
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  CPU byte offered; pushed when a_valid && a_ready.
- a_data  in  8  CPU byte.
- a_ready  out  1  FIFO not full (count < DEPTH).
- b_req  in  1  requester B has a byte; held high until b_ack.
- b_data  in  8  requester B byte; must be stable while b_req is high.
- b_ack  out  1  one-cycle pulse; B byte taken.
- fifo_count  out  AW+1  current FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky flag; set by a_valid while !a_ready.
- tx_wr  out  1  one-cycle write strobe to buart wr.
- tx_data  out  8  byte to buart tx_data; registered.
- tx_busy  in  1  buart busy.

Behaviour:
- Reset, in any state: tx_wr=0, tx_data=0, b_ack=0, fifo_count=0, a_ready=1, ovf=0, state=IDLE, last_grant=B.
  - FIFO contents are discarded.
  - A byte already inside buart is not affected.
- FIFO:
  - Synchronous, read/write pointers AW bits, wrapping modulo DEPTH.
  - Push at edge when a_valid && a_ready.
  - Pop only in ISSUE with grant=A.
  - Simultaneous push and pop leaves count unchanged.
  - No bypass: a pushed byte is eligible one cycle after the push edge.
  - a_valid && !a_ready: byte dropped, ovf<=1; ovf stays set until reset.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - A is pending when count>0. B is pending when b_req=1.
  - If tx_busy=0 and any requester is pending, grant and go to ISSUE.
  - Grant rule: one pending requester wins. If both are pending, grant the requester that is not last_grant.
  - On grant: tx_data <= FIFO head (A) or b_data (B); last_grant <= grant.
  - If tx_busy=1, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - tx_wr=1.
  - Grant A: pop the FIFO.
  - Grant B: b_ack=1.
  - Next state WAIT_BUSY; clear the timeout counter.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise increment the counter; when it reaches BUSY_TO, go to IDLE (a missed busy edge must not hang the scheduler).
- WAIT_DONE: stay while tx_busy=1; go to IDLE when tx_busy=0.
- Latency: A push edge at cycle N → count=1 at N+1 → tx_wr high at N+2 (idle UART, no contention). Same for B: b_req high at cycle N → tx_wr and b_ack at N+1.
- tx_wr and b_ack are never asserted outside ISSUE. At most one byte is in flight.
- B de-asserting b_req before grant withdraws the request, with no ack. After grant, b_req and b_data are ignored until the next IDLE.
- tx_data holds its value after ISSUE until the next grant.

Test Plan:
- Reset then single CPU byte 0x41, tx_busy modelled high 1 cycle after tx_wr for 10 cycles → one tx_wr pulse at push+2 with tx_data=0x41; fifo_count 1→0; FSM returns to IDLE after busy falls.
- Push 17 bytes 0x00..0x10 back-to-back with tx_busy held high → a_ready=0 after 16 pushes; byte 0x10 dropped; ovf=1; fifo_count=16. Release busy → bytes 0x00..0x0F transmitted in order, count wraps pointers correctly.
- A FIFO holds 0x10,0x11 and b_req with b_data=0xB0, all pending from reset → grant order 0x10, 0xB0, 0x11; b_ack coincides with the 0xB0 tx_wr.
- tx_busy never rises after tx_wr → FSM returns to IDLE exactly BUSY_TO cycles after WAIT_BUSY entry; the next queued byte is issued.
- Reset asserted during WAIT_DONE with 3 bytes queued → next cycle fifo_count=0, tx_wr=0, a_ready=1, ovf=0; no further tx_wr after busy falls.
- b_req raised while tx_busy=1, then dropped before busy falls → no b_ack and no tx_wr for B.
